uart_sample_assembler: RTL
==========================

Name: uart_sample_assembler

Overview:
- Parametrised successor to the single-purpose byte-to-sample converter between uart_rx and bit_changer_seq.
- Collects received UART bytes into samples of BPS bits, then packs FRAME_SIZE samples into one frame for bit_changer_seq.
- Adds configurable byte order, a valid/accept output handshake with overrun detection, and inter-byte timeout resynchronisation.

Parameters:
- BPS, 16: bits per sample. Must be a multiple of 8 and at least 8.
- FRAME_SIZE, 1: samples per output frame. Must be at least 1.
- LSB_FIRST, 1: 1 = first byte of a sample is its least significant byte; 0 = most significant byte first.
- TIMEOUT_CLKS, 8700: idle clocks allowed between bytes before a partial frame is discarded.

Ports:
- in_clk, input, 1: clock, rising edge.
- in_rst_n, input, 1: asynchronous active-low reset.
- in_uart_ready, input, 1: one-cycle byte strobe from uart_rx.
- in_uart_frame, input, 8: received byte; qualified by in_uart_ready.
- in_accept, input, 1: downstream takes the frame while out_valid=1.
- out_frame, output, FRAME_SIZE*BPS: assembled frame. Sample k occupies bits [k*BPS +: BPS]; sample 0 is the first received.
- out_valid, output, 1: out_frame holds an unconsumed frame.
- out_overrun, output, 1: sticky flag; a completed frame was dropped.
- out_timeout, output, 1: one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_frame=0, out_valid=0, out_overrun=0, out_timeout=0.
  - Byte and sample counters=0, working register=0, idle counter=0.
- Working register: byte counter 0..BPS/8-1 and sample counter 0..FRAME_SIZE-1.
- Byte placement:
  - LSB_FIRST=1: byte j of a sample goes to bits [8j+7:8j].
  - LSB_FIRST=0: byte j goes to bits [BPS-1-8j -: 8].
- Counters advance only on cycles with in_uart_ready=1. Both wrap to 0 on the byte that completes a frame.
- State machine:
  - IDLE: counters zero. A byte moves to COLLECT, unless BPS=8 and FRAME_SIZE=1, in which case the frame completes immediately.
  - COLLECT: accumulating bytes. The last byte of the frame completes it and returns to IDLE.
  - out_valid is an independent holding flag, not an FSM state.
- Completion latency: the completing byte is sampled at edge t; out_frame and out_valid=1 are updated at edge t+1.
- Handshake:
  - out_valid stays 1 and out_frame stays stable until a cycle with in_accept=1; out_valid clears on the following edge.
  - in_accept while out_valid=0 is ignored.
- Frame completes while out_valid=1:
  - With in_accept=1 in the same cycle: load the new frame, out_valid stays 1, no overrun.
  - Otherwise: drop the new frame, set out_overrun, keep the held frame. Assembly continues.
- out_overrun clears only on reset.
- Timeout:
  - The idle counter runs only in COLLECT and resets on every byte.
  - If it reaches TIMEOUT_CLKS-1 with no byte that cycle: discard the partial frame, return to IDLE, pulse out_timeout for one cycle.
  - A byte arriving in the expiry cycle wins; no timeout.
  - The held out_frame/out_valid are unaffected.
- Reset asserted mid-frame discards all partial and held data.

Optional Feature:
- Macro: UART_ASM_TIMEOUT_EN.
- Defined: idle counter and timeout logic as above.
- Undefined:
  - No idle counter is synthesised and TIMEOUT_CLKS is unused.
  - out_timeout is tied to 0.
  - Partial frames persist indefinitely until completed or reset.

Decomposition:
- Shared package uart_pkg holds:
  - Constant BYTE_W=8.
  - Function bytes_per_sample(BPS)=BPS/8.
  - Counter-width helpers based on $clog2.
  - Typedef of the state enum {ASM_IDLE, ASM_COLLECT}.
- Sub-module byte_to_word_packer: byte counter plus placement into one BPS sample with LSB_FIRST. It is instantiated once; the top owns sample packing, handshake and timeout.

Test Plan:
- BPS=16, FRAME_SIZE=1, LSB_FIRST=1, in_accept tied 1; bytes 3F,FF,01,F0 -> out_frame 16'hFF3F then 16'hF001, each valid one cycle after the second byte.
- Same with LSB_FIRST=0; bytes 3F,FF -> out_frame 16'h3FFF.
- FRAME_SIZE=2; bytes 11,22,33,44 -> out_frame 32'h44332211; out_valid rises once, after byte 44 only.
- in_accept=0; bytes 3F,FF,01,F0 -> out_frame holds 16'hFF3F, out_overrun=1 after F0. Then in_accept=1 -> out_valid clears; out_overrun stays 1.
- UART_ASM_TIMEOUT_EN, TIMEOUT_CLKS=100; byte AA, idle 100 clocks, bytes 01,02 -> out_timeout pulses once, out_frame 16'h0201. With the macro undefined -> 16'h01AA.
- Assert in_rst_n=0 after one byte, release, send 01,F0 -> all outputs 0 during reset, then out_frame 16'hF001.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, helpers and state type for the UART sample assembler.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ASM_IDLE,
    ASM_COLLECT
  } asm_state_e;

  function automatic int unsigned bytes_per_sample(input int unsigned bps);
    return bps / BYTE_W;
  endfunction

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Byte counter and byte placement for one BPS-bit sample.
// o_word is the partial sample with the current byte merged in; it is meaningful when
// o_word_done is high.
module byte_to_word_packer
  import uart_pkg::*;
#(
  parameter int unsigned BPS       = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_byte_valid,
  input  logic [7:0]     i_byte,
  input  logic           i_clear,
  output logic [BPS-1:0] o_word,
  output logic           o_word_done
);

  localparam int unsigned     NBytes   = bytes_per_sample(BPS);
  localparam int unsigned     CntW     = cnt_w(NBytes);
  localparam logic [CntW-1:0] LastByte = CntW'(NBytes - 1);

  logic [CntW-1:0] r_byte_cnt;
  logic [BPS-1:0]  r_word;
  logic [BPS-1:0]  w_word;
  logic            w_last;

  assign w_last      = (r_byte_cnt == LastByte);
  assign o_word_done = i_byte_valid && w_last;
  assign o_word      = w_word;

  // Drop the incoming byte into the slot selected by the byte counter and byte order.
  always_comb begin
    w_word = r_word;
    for (int j = 0; j < int'(NBytes); j++) begin
      if (r_byte_cnt == CntW'(j)) begin
        if (LSB_FIRST) begin
          w_word[j*BYTE_W +: BYTE_W] = i_byte;
        end else begin
          w_word[BPS-BYTE_W-j*BYTE_W +: BYTE_W] = i_byte;
        end
      end
    end
  end

  // Counter and partial sample restart after the last byte of a sample or a discard.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_byte_valid) begin
      if (w_last) begin
        r_byte_cnt <= '0;
        r_word     <= '0;
      end else begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
        r_word     <= w_word;
      end
    end else if (i_clear) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end
  end

endmodule

// File: rtl/uart_sample_assembler.sv
// Assembles UART bytes into BPS-bit samples and FRAME_SIZE-sample frames, with a
// valid/accept output handshake and sticky overrun flag.
// Optional macro UART_ASM_TIMEOUT_EN adds inter-byte timeout that discards partial frames.
module uart_sample_assembler
  import uart_pkg::*;
#(
  parameter int unsigned BPS          = 16,
  parameter int unsigned FRAME_SIZE   = 1,
  parameter bit          LSB_FIRST    = 1'b1,
  parameter int unsigned TIMEOUT_CLKS = 8700
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_uart_ready,
  input  logic [7:0]                in_uart_frame,
  input  logic                      in_accept,
  output logic [FRAME_SIZE*BPS-1:0] out_frame,
  output logic                      out_valid,
  output logic                      out_overrun,
  output logic                      out_timeout
);

  localparam int unsigned     FrameW     = FRAME_SIZE * BPS;
  localparam int unsigned     SmpW       = cnt_w(FRAME_SIZE);
  localparam logic [SmpW-1:0] LastSample = SmpW'(FRAME_SIZE - 1);

  asm_state_e        r_state;
  asm_state_e        w_state_next;
  logic [SmpW-1:0]   r_sample_cnt;
  logic [FrameW-1:0] r_samples;
  logic [FrameW-1:0] w_samples_next;
  logic [BPS-1:0]    w_word;
  logic              w_word_done;
  logic              w_frame_done;
  logic              w_timeout;
  logic              r_cmpl;
  logic [FrameW-1:0] r_cmpl_frame;
  logic [FrameW-1:0] r_frame;
  logic              r_valid;
  logic              r_overrun;
  logic              r_timeout;

  byte_to_word_packer #(
    .BPS      (BPS),
    .LSB_FIRST(LSB_FIRST)
  ) u_packer (
    .i_clk       (in_clk),
    .i_rst_n     (in_rst_n),
    .i_byte_valid(in_uart_ready),
    .i_byte      (in_uart_frame),
    .i_clear     (w_timeout),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  assign w_frame_done = w_word_done && (r_sample_cnt == LastSample);

  // Working frame with the just-finished sample placed in its slot.
  always_comb begin
    w_samples_next = r_samples;
    for (int k = 0; k < int'(FRAME_SIZE); k++) begin
      if (r_sample_cnt == SmpW'(k)) begin
        w_samples_next[k*BPS +: BPS] = w_word;
      end
    end
  end

  // Sample counter and stored samples; cleared when a frame completes or is discarded.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_sample_cnt <= '0;
      r_samples    <= '0;
    end else if (w_word_done) begin
      if (w_frame_done) begin
        r_sample_cnt <= '0;
        r_samples    <= '0;
      end else begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
        r_samples    <= w_samples_next;
      end
    end else if (w_timeout) begin
      r_sample_cnt <= '0;
      r_samples    <= '0;
    end
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ASM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: any byte that leaves the frame unfinished means a frame is in progress.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ASM_IDLE: begin
        if (in_uart_ready) begin
          w_state_next = w_frame_done ? ASM_IDLE : ASM_COLLECT;
        end
      end
      ASM_COLLECT: begin
        if (w_frame_done || w_timeout) begin
          w_state_next = ASM_IDLE;
        end
      end
      default: w_state_next = ASM_IDLE;
    endcase
  end

`ifdef UART_ASM_TIMEOUT_EN
  localparam int unsigned      IdleW    = cnt_w(TIMEOUT_CLKS);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CLKS - 1);

  logic [IdleW-1:0] r_idle_cnt;

  // A byte in the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state == ASM_COLLECT) && !in_uart_ready && (r_idle_cnt == IdleLast);

  // Idle clocks since the last byte, counted only while a frame is in progress.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != ASM_COLLECT) || in_uart_ready || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  // Keeps TIMEOUT_CLKS referenced while the timeout logic is compiled out.
  if (TIMEOUT_CLKS == 0) begin : g_timeout_unused
  end
`endif

  // Stage a completed frame so outputs change one edge after the completing byte.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_cmpl       <= 1'b0;
      r_cmpl_frame <= '0;
    end else begin
      r_cmpl <= w_frame_done;
      if (w_frame_done) begin
        r_cmpl_frame <= w_samples_next;
      end
    end
  end

  // Output holding register: accept handshake, and overrun when a new frame cannot land.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_frame   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_cmpl) begin
      if (!r_valid || in_accept) begin
        r_frame <= r_cmpl_frame;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (in_accept) begin
      r_valid <= 1'b0;
    end
  end

  // One-cycle timeout pulse.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
    end
  end

  assign out_frame   = r_frame;
  assign out_valid   = r_valid;
  assign out_overrun = r_overrun;
  assign out_timeout = r_timeout;

endmodule
